spi_shift_engine: RTL



---
 rtl/spi_shift_engine.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one full-duplex DATA_WIDTH-bit transfer per accepted
// start, MSB first, CPHA=0 (sample on leading sclk edge, shift on trailing edge).
// Serial clock polarity and half-period are latched at acceptance.
//
// Ports:
//   clk             system clock, all logic on its rising edge
//   reset           synchronous active-high reset
//   serclk_polarity CPOL, idle level of sclk
//   serclk_speed    sclk half-period = serclk_speed+1 clk cycles
//   tx_data         byte to send, captured on accepted start
//   start           transfer request, accepted only while busy=0
//   busy            high from the cycle after acceptance until done
//   done            one-cycle pulse when rx_data is updated
//   rx_data         last received byte
//   sclk/mosi/miso  SPI serial clock, data out, data in
//   ss_L            active-low slave select
module spi_shift_engine #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serclk_polarity,
  input  logic [3:0]            serclk_speed,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ss_L
);

  typedef enum logic [2:0] {StIdle, StSetup, StLead, StTrail, StHold} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            speed_q, speed_d;
  logic [3:0]            bits_q, bits_d;
  logic                  cpol_q, cpol_d;
  logic                  sample_q, sample_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  ss_q, ss_d;

  logic accept;
  logic half_evt;
  logic last_bit;

  assign accept   = (state_q == StIdle) && start && !busy_q;
  // Counter runs 0..speed_q, i.e. half = speed_q+1 cycles per phase.
  assign half_evt = (cnt_q == speed_q);
  // Trailing edge that completes the final bit.
  assign last_bit = (bits_q == 4'(DATA_WIDTH - 1));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      speed_q  <= '0;
      bits_q   <= '0;
      cpol_q   <= 1'b0;
      sample_q <= 1'b0;
      shreg_q  <= '0;
      rx_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ss_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      speed_q  <= speed_d;
      bits_q   <= bits_d;
      cpol_q   <= cpol_d;
      sample_q <= sample_d;
      shreg_q  <= shreg_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ss_q     <= ss_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:           if (accept)   state_d = StSetup;
      StSetup, StTrail: if (half_evt) state_d = StLead;
      StLead:           if (half_evt) state_d = last_bit ? StHold : StTrail;
      StHold:           if (half_evt) state_d = StIdle;
      default:                        state_d = StIdle;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d    = (state_q == StIdle || half_evt) ? 4'd0 : cnt_q + 4'd1;
    speed_d  = speed_q;
    bits_d   = bits_q;
    cpol_d   = cpol_q;
    sample_d = sample_q;
    shreg_d  = shreg_q;
    rx_d     = rx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    ss_d     = ss_q;
    unique case (state_q)
      StIdle: begin
        // Idle sclk tracks the configured polarity with one cycle of latency.
        sclk_d = serclk_polarity;
        if (accept) begin
          cpol_d  = serclk_polarity;
          speed_d = serclk_speed;
          shreg_d = tx_data;
          bits_d  = '0;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          mosi_d  = tx_data[DATA_WIDTH-1];
        end
      end
      StSetup, StTrail: begin
        if (half_evt) begin
          sclk_d   = ~cpol_q;
          sample_d = miso;
        end
      end
      StLead: begin
        if (half_evt) begin
          sclk_d = cpol_q;
          bits_d = bits_q + 4'd1;
          // Sampled bit enters at the LSB as the next tx bit moves into the MSB.
          shreg_d = {shreg_q[DATA_WIDTH-2:0], sample_q};
          if (!last_bit) mosi_d = shreg_q[DATA_WIDTH-2];
        end
      end
      StHold: begin
        if (half_evt) begin
          ss_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          rx_d   = shreg_q;
        end
      end
      default: ;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign ss_L    = ss_q;

endmodule
